// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD sequencer state type, pin-word layout and command codes
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} lcd_state_e;
  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RW_BIT = 9;
  localparam int LCD_RS_BIT = 8;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME = 8'h02;
  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer producing the io_lcd pin word with setup/pulse/hold/exec timing
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 25,
  parameter int HOLD_CYC = 2,
  parameter int EXEC_CYC = 2000,
  parameter int CLEAR_EXEC_CYC = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  input  logic        lcd_on_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] io_lcd_o
);
  localparam int MAX_CYC = max_i(max_i(max_i(SETUP_CYC, PULSE_CYC), max_i(HOLD_CYC, EXEC_CYC)), CLEAR_EXEC_CYC);
  localparam int CNT_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_EXEC_CYC - 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || EXEC_CYC < 1 || CLEAR_EXEC_CYC < 1) begin : g_bad_param
    $error("lcd_ctrl: every cycle parameter must be at least 1");
  end

  lcd_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic rs_q, clr_q, en_q, on_q, busy_q, done_q;
  logic [7:0] data_q;
  logic accept, cnt_zero;

  assign req_ready_o = (state == IDLE);
  assign accept = req_valid_i & req_ready_o;
  assign cnt_zero = (cnt == '0);
  assign busy_o = busy_q;
  assign done_o = done_q;

  always_comb begin
    state_n = state;
    cnt_n = cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (accept) begin
          state_n = SETUP;
          cnt_n = SETUP_LD;
        end
      end
      SETUP: if (cnt_zero) begin
        state_n = PULSE;
        cnt_n = PULSE_LD;
      end
      PULSE: if (cnt_zero) begin
        state_n = HOLD;
        cnt_n = HOLD_LD;
      end
      HOLD: if (cnt_zero) begin
        state_n = EXEC;
        cnt_n = clr_q ? CLEAR_LD : EXEC_LD;
      end
      EXEC: if (cnt_zero) begin
        state_n = IDLE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      rs_q <= 1'b0;
      data_q <= '0;
      clr_q <= 1'b0;
      en_q <= 1'b0;
      on_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      en_q <= (state_n == PULSE);
      on_q <= lcd_on_i;
      busy_q <= (state_n != IDLE);
      done_q <= (state == EXEC) && cnt_zero;
      if (accept) begin
        rs_q <= req_rs_i;
        data_q <= req_data_i;
        clr_q <= !req_rs_i && (req_data_i[7:1] == LCD_CMD_CLEAR[7:1] || req_data_i[7:1] == LCD_CMD_HOME[7:1]);
      end
    end
  end

  always_comb begin
    io_lcd_o = '0;
    io_lcd_o[LCD_ON_BIT] = on_q;
    io_lcd_o[LCD_EN_BIT] = en_q;
    io_lcd_o[LCD_RW_BIT] = 1'b0;
    io_lcd_o[LCD_RS_BIT] = rs_q;
    io_lcd_o[7:0] = data_q;
  end
endmodule
